sar_scan_ctrl: RTL and testbench

- Multi-channel scan sequencer in front of the fsm_sar_bs successive-approximation converter.
- Walks an enabled-channel mask in ascending order and drives the analog mux select.
- Per channel: waits a settling interval, pulses the converter start, waits for end-of-conversion (with timeout), then streams the tagged result out on a valid/ready interface.
- Supports single-shot (triggered) and continuous scanning.

---
 rtl/sar_pkg.sv | 8 +
 rtl/sar_prio_enc.sv | 17 +
 rtl/sar_scan_ctrl.sv | 119 +++++++++++
 tb/tb_sar_scan_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared types and helpers for the SAR scan controller
package sar_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, OUT, ABORT} state_t;
  localparam int DefWidth = 6;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sar_prio_enc.sv
// sar_prio_enc: lowest-set-bit priority encoder with any-set flag
module sar_prio_enc
  import sar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  any
);
  localparam int W = idx_w(N);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign any = |req;
endmodule

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel scan sequencer driving an analog mux and a SAR converter
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter int Width         = DefWidth,
  parameter int NumCh         = 4,
  parameter int SettleCycles  = 4,
  parameter int TimeoutCycles = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      trig_i,
  input  logic                      cont_i,
  input  logic [NumCh-1:0]          ch_mask_i,
  output logic [idx_w(NumCh)-1:0]   mux_sel_o,
  output logic                      sar_start_o,
  output logic                      sar_clr_o,
  input  logic                      sar_eoc_i,
  input  logic [Width-1:0]          sar_result_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [Width-1:0]          res_data_o,
  output logic [idx_w(NumCh)-1:0]   res_ch_o,
  output logic                      busy_o,
  output logic                      scan_done_o,
  output logic                      timeout_err_o
);
  localparam int ChW = idx_w(NumCh);
  localparam int SW  = $clog2(SettleCycles + 1);
  localparam int TW  = $clog2(TimeoutCycles);
  state_t           state;
  logic [NumCh-1:0] scan_mask, rem_mask;
  logic [ChW-1:0]   ch, first_ch, next_ch;
  logic             first_any, next_any;
  logic [SW-1:0]    settle_cnt;
  logic [TW-1:0]    to_cnt;
  assign rem_mask  = scan_mask & ~(NumCh'(1) << ch);
  assign mux_sel_o = ch;
  sar_prio_enc #(.N(NumCh)) u_first (.req(ch_mask_i), .idx(first_ch), .any(first_any));
  sar_prio_enc #(.N(NumCh)) u_next  (.req(rem_mask),  .idx(next_ch),  .any(next_any));
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      scan_mask     <= '0;
      ch            <= '0;
      settle_cnt    <= '0;
      to_cnt        <= '0;
      sar_start_o   <= 1'b0;
      sar_clr_o     <= 1'b0;
      res_valid_o   <= 1'b0;
      res_data_o    <= '0;
      res_ch_o      <= '0;
      busy_o        <= 1'b0;
      scan_done_o   <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      sar_start_o <= 1'b0;
      sar_clr_o   <= 1'b0;
      scan_done_o <= 1'b0;
      if (state != IDLE && !en_i) begin
        state       <= IDLE;
        busy_o      <= 1'b0;
        res_valid_o <= 1'b0;
        sar_clr_o   <= state inside {START, WAIT};
      end else begin
        case (state)
          IDLE: if (en_i && (trig_i || cont_i) && first_any) begin
            state         <= SETTLE;
            busy_o        <= 1'b1;
            scan_mask     <= ch_mask_i;
            ch            <= first_ch;
            settle_cnt    <= SW'(SettleCycles - 1);
            timeout_err_o <= 1'b0;
          end
          SETTLE: if (settle_cnt == '0) begin
            state       <= START;
            sar_start_o <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
          START: begin
            state  <= WAIT;
            to_cnt <= '0;
          end
          // eoc is checked first so it wins on the timeout threshold cycle
          WAIT: if (sar_eoc_i) begin
            state       <= OUT;
            res_valid_o <= 1'b1;
            res_data_o  <= sar_result_i;
            res_ch_o    <= ch;
          end else if (to_cnt == TW'(TimeoutCycles - 2)) begin
            state         <= ABORT;
            sar_clr_o     <= 1'b1;
            timeout_err_o <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
          OUT, ABORT: if (state == ABORT || res_ready_i) begin
            res_valid_o <= 1'b0;
            scan_done_o <= !next_any;
            // continuous mode relatches the mask and goes straight back to SETTLE
            if (next_any || (cont_i && first_any)) begin
              state      <= SETTLE;
              scan_mask  <= next_any ? rem_mask : ch_mask_i;
              ch         <= next_any ? next_ch : first_ch;
              settle_cnt <= SW'(SettleCycles - 1);
            end else begin
              state     <= IDLE;
              busy_o    <= 1'b0;
              scan_mask <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: directed self-checking bench for sar_scan_ctrl
module tb_sar_scan_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni, en_i, trig_i, cont_i, sar_eoc_i, res_ready_i;
  logic [3:0] ch_mask_i;
  logic [5:0] sar_result_i, res_data_o;
  logic [1:0] mux_sel_o, res_ch_o;
  logic       sar_start_o, sar_clr_o, res_valid_o, busy_o, scan_done_o, timeout_err_o;
  int         total = 0;
  int         bad = 0;
  int         n;
  logic       seen;

  always #5 clk_i = ~clk_i;

  sar_scan_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .trig_i(trig_i), .cont_i(cont_i),
    .ch_mask_i(ch_mask_i), .mux_sel_o(mux_sel_o), .sar_start_o(sar_start_o),
    .sar_clr_o(sar_clr_o), .sar_eoc_i(sar_eoc_i), .sar_result_i(sar_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_ch_o(res_ch_o), .busy_o(busy_o), .scan_done_o(scan_done_o),
    .timeout_err_o(timeout_err_o)
  );

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called on the first negedge after SETTLE entry; start must follow 4 cycles later
  task automatic start_phase(input logic [1:0] ch);
    int k = 0;
    while (!sar_start_o && k < 50) begin
      tick();
      k++;
    end
    chk("settle_lat", k, 4);
    chk("mux_sel", mux_sel_o, ch);
  endtask

  // converter answers 8 cycles after the start pulse
  task automatic eoc_phase(input logic [1:0] ch, input logic [5:0] d);
    repeat (7) tick();
    sar_eoc_i = 1'b1;
    sar_result_i = d;
    tick();
    sar_eoc_i = 1'b0;
    sar_result_i = 6'h00;
    chk("res_valid", res_valid_o, 1);
    chk("res_data", res_data_o, d);
    chk("res_ch", res_ch_o, ch);
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; trig_i = 1'b0; cont_i = 1'b0; ch_mask_i = 4'b0000;
    sar_eoc_i = 1'b0; sar_result_i = 6'h00; res_ready_i = 1'b0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", res_valid_o, 0);
    chk("rst_terr", timeout_err_o, 0);
    chk("rst_start", sar_start_o, 0);
    rst_ni = 1'b1;

    // trigger with an empty mask is ignored
    en_i = 1'b1; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    tick();
    chk("empty_busy", busy_o, 0);
    chk("empty_done", scan_done_o, 0);

    // single scan over 1011, ch2 skipped
    ch_mask_i = 4'b1011; res_ready_i = 1'b1; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    chk("scan_busy", busy_o, 1);
    start_phase(2'd0); eoc_phase(2'd0, 6'h15);
    tick();
    chk("ch0_done", scan_done_o, 0);
    chk("ch0_drop", res_valid_o, 0);
    start_phase(2'd1); eoc_phase(2'd1, 6'h2A);
    tick();
    chk("ch1_done", scan_done_o, 0);
    start_phase(2'd3); eoc_phase(2'd3, 6'h3F);
    tick();
    chk("scan_done", scan_done_o, 1);
    chk("scan_idle", busy_o, 0);
    tick();
    chk("done_pulse", scan_done_o, 0);

    // backpressure holds the result and blocks the next start
    ch_mask_i = 4'b0001; res_ready_i = 1'b0; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    start_phase(2'd0); eoc_phase(2'd0, 6'h11);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", res_valid_o, 1);
      chk("bp_data", res_data_o, 6'h11);
      chk("bp_ch", res_ch_o, 2'd0);
      chk("bp_nostart", sar_start_o, 0);
    end
    res_ready_i = 1'b1;
    tick();
    chk("bp_accept", res_valid_o, 0);
    chk("bp_done", scan_done_o, 1);

    // timeout on ch1
    ch_mask_i = 4'b0011; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    start_phase(2'd0); eoc_phase(2'd0, 6'h05);
    tick();
    start_phase(2'd1);
    n = 0; seen = 1'b0;
    while (!sar_clr_o && n < 60) begin
      tick();
      n++;
      seen |= res_valid_o;
    end
    chk("to_lat", n, 32);
    chk("to_noresult", seen, 0);
    chk("to_err", timeout_err_o, 1);
    tick();
    chk("to_clr_pulse", sar_clr_o, 0);
    chk("to_done", scan_done_o, 1);
    chk("to_idle", busy_o, 0);
    tick();
    chk("to_sticky", timeout_err_o, 1);

    // continuous scan on ch0, new scan clears the sticky error
    ch_mask_i = 4'b0001; cont_i = 1'b1;
    tick();
    chk("cont_busy", busy_o, 1);
    chk("cont_terr_clr", timeout_err_o, 0);
    start_phase(2'd0); eoc_phase(2'd0, 6'h21);
    tick();
    chk("cont_done1", scan_done_o, 1);
    chk("cont_busy1", busy_o, 1);
    start_phase(2'd0); eoc_phase(2'd0, 6'h22);
    cont_i = 1'b0;
    tick();
    chk("cont_done2", scan_done_o, 1);
    chk("cont_idle", busy_o, 0);
    tick();
    chk("cont_stay", busy_o, 0);

    // enable dropped during WAIT
    ch_mask_i = 4'b0100; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    start_phase(2'd2);
    tick(); tick();
    en_i = 1'b0;
    tick();
    chk("ab_busy", busy_o, 0);
    chk("ab_clr", sar_clr_o, 1);
    chk("ab_valid", res_valid_o, 0);
    chk("ab_done", scan_done_o, 0);
    tick();
    chk("ab_clr_pulse", sar_clr_o, 0);
    chk("ab_done2", scan_done_o, 0);
    en_i = 1'b1;

    // reset while a result is pending and the error flag is set
    ch_mask_i = 4'b0011; res_ready_i = 1'b0; trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    start_phase(2'd0);
    n = 0;
    while (!sar_clr_o && n < 60) begin
      tick();
      n++;
    end
    tick();
    start_phase(2'd1); eoc_phase(2'd1, 6'h3A);
    chk("pre_rst_terr", timeout_err_o, 1);
    rst_ni = 1'b0;
    tick();
    chk("mrst_valid", res_valid_o, 0);
    chk("mrst_terr", timeout_err_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_data", res_data_o, 6'h00);
    chk("mrst_ch", res_ch_o, 2'd0);
    chk("mrst_mux", mux_sel_o, 2'd0);
    chk("mrst_pulses", {sar_start_o, sar_clr_o, scan_done_o}, 3'b000);
    rst_ni = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
